moore_seq_detector: RTL
=======================

// Module: moore_seq_detector
// PURPOSE
//  Parametrised Moore serial pattern detector; successor to the fixed 4-state Moore FSM.
//  Detects a PAT_LEN-bit PATTERN on serial input X, MSB first.
//  Supports overlapping or non-overlapping match mode, an input-qualify enable and a saturating match counter.
//  Sits at the serial-input front end; outp and Estado feed downstream control and debug.
// PARAMETERS
//  PAT_LEN  4        pattern length in bits, >=2
//  PATTERN  4'b1011  pattern; PATTERN[PAT_LEN-1] is compared first
//  OVERLAP  1        1: overlapping matches allowed; 0: restart after each match
//  CNT_W    8        match counter width
//  STATE_W  (localparam) $clog2(PAT_LEN+1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  en         in   1        X is sampled only when en=1
//  X          in   1        serial data bit
//  cnt_clr    in   1        synchronous clear of match_cnt
//  outp       out  1        Moore match flag: 1 while in the match state
//  Estado     out  STATE_W  current state (number of pattern bits matched)
//  match_cnt  out  CNT_W    number of matches, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=0, Estado=0, outp=0, match_cnt=0. Asserting rst mid-pattern clears immediately; no clock needed.
//  - States: 0..PAT_LEN; state k = k leading pattern bits matched. PAT_LEN is the match state.
//  - en=0: state, outp and match_cnt hold; X is ignored. cnt_clr still acts.
//  - en=1, state k<PAT_LEN:
//      X==PATTERN[PAT_LEN-1-k] -> k+1.
//      Otherwise -> longest proper suffix of (matched prefix, X) that is a pattern prefix (KMP fallback).
//  - en=1, state PAT_LEN:
//      OVERLAP=1 -> treat as state fail(PAT_LEN), then apply X as above.
//      OVERLAP=0 -> treat as state 0, then apply X.
//  - Fallback table is computed at elaboration from PATTERN. No runtime search.
//  - Any state code outside 0..PAT_LEN -> next state 0, outp=0.
//  - outp is a flop loaded with (next_state==PAT_LEN), so outp==(state==PAT_LEN) at all times.
//    No combinational path from X to outp.
//  - Latency: the last pattern bit is sampled at edge t; outp=1 from edge t until the next sampled edge.
//  - match_cnt: +1 on each edge where en=1 and next_state==PAT_LEN. Saturates at 2^CNT_W-1 (no wrap).
//  - cnt_clr=1 forces match_cnt to 0 at the edge. It has priority over a same-cycle increment.
//  - State update is a single registered process; next-state and fallback logic is combinational.
// STRUCTURE
//  - Package seq_det_pkg: function kmp_next(pattern, len, k, x), used at elaboration to build the next-state table.
//    Also holds the state-width helper function.
//  - Sub-module sat_counter (params W; ports clk, rst, clr, inc, q): saturating counter with sync clear and async active-low reset.
//  - Top: next-state table, state register, outp flop, sat_counter instance.
// TESTING
//  1. PATTERN=1011, OVERLAP=1, en=1; X=1,0,1,1,0,1,1 -> outp=1 after bits 4 and 7; match_cnt=2.
//  2. Same stream, OVERLAP=0 -> outp=1 only after bit 4; Estado after bit 7 =1; match_cnt=1.
//  3. Fallback: X=1,1,0,1,1 -> Estado 1,1,2,3,4; outp=1 only after bit 5.
//  4. Enable gap: X=1,0 (en=1), then 3 cycles en=0 with X=0 -> Estado holds 2; then X=1,1 with en=1 -> match.
//  5. Reset mid-op: after X=1,0,1 (Estado=3), pull rst low between edges -> Estado=0, outp=0 at once.
//     After release, X=1,1 gives no match.
//  6. CNT_W=2: 5 matches -> match_cnt=3 (saturated). Then cnt_clr=1 in the same cycle as a match -> match_cnt=0, outp=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state-width sizing and the
// KMP transition function used to build the next-state table at elaboration.
package seq_det_pkg;

  function automatic int state_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

  // Next state from state k (k leading bits matched) after bit x: the longest
  // suffix of (matched prefix, x) that is also a pattern prefix, capped at len.
  function automatic int kmp_next(input logic [31:0] pattern, input int len,
                                  input int k, input logic x);
    logic [32:0] s;
    logic        ok;
    int          best;
    s    = '0;
    best = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < k) s[i] = pattern[len-1-i];
    end
    s[k] = x;
    for (int j = 1; j <= 32; j++) begin
      if (j <= k + 1 && j <= len) begin
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
          if (i < j && s[k+1-j+i] != pattern[len-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && q != MAX) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector (MSB first) with overlap mode,
// input-qualify enable and a saturating match counter.
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int                   CNT_W   = 8,
  localparam int                  STATE_W = state_width(PAT_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               X,
  input  logic               cnt_clr,
  output logic               outp,
  output logic [STATE_W-1:0] Estado,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [STATE_W-1:0] MATCH_ST = STATE_W'(PAT_LEN);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] nxt_state;
  logic [STATE_W-1:0] nxt_tab [0:PAT_LEN][0:1];

  // Constant transition table; the match row restarts from the KMP failure
  // state when overlapping, or from state 0 when not.
  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int SRC = (k == PAT_LEN && !OVERLAP) ? 0 : k;
      assign nxt_tab[k][b] = STATE_W'(kmp_next(32'(PATTERN), PAT_LEN, SRC, 1'(b)));
    end
  end

  // NOTE: nxt_state gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_state = state_q;
    if (state_q > MATCH_ST) begin
      nxt_state = '0;
    end else if (en) begin
      nxt_state = nxt_tab[state_q][X];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      outp    <= 1'b0;
    end else begin
      state_q <= nxt_state;
      outp    <= (nxt_state == MATCH_ST);
    end
  end

  assign Estado = state_q;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (en && (nxt_state == MATCH_ST)),
    .q   (match_cnt)
  );

endmodule
